holiday_lights_monitor: RTL and testbench
=========================================

# holiday_lights_monitor

Observer for the 16-bit holiday-light LED bus. It samples the pattern each cycle and decodes the selected run width (switch code 0–7) and the run position. It counts left-rotation steps and full laps, and flags any change that is not a legal single-step rotation. It sits on the same clock as the light generator and taps its `led` output as a self-check and status source for display logic.

## Interface
- `countnum`, 100000000, expected cycles between rotation steps; stall threshold is 2*countnum; must be ≤ 2^31−1.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `led_in`  in  16  LED pattern under observation.
- `resync`  in  1  synchronous return to IDLE; clears counters and `err`; `rst` has priority.
- `valid`  out  1  current pattern is a legal run.
- `code`  out  3  run width − 1 (equals generator switch code).
- `pos`  out  4  index of run's first lit bit (lowest, circularly).
- `running`  out  1  state is RUN.
- `step`  out  1  one-cycle pulse per detected left rotation.
- `lap`  out  1  one-cycle pulse when 16 steps complete.
- `laps`  out  8  lap count, wraps 255→0.
- `stalled`  out  1  RUN with no step for ≥ 2*countnum cycles.
- `err`  out  1  sticky fault flag.

## Operation
- Legal pattern: exactly one circular contiguous run of k ones, 1 ≤ k ≤ 8. All-zero, more than 8 ones, or several runs is illegal.
- Run start: bit i with `led_in[i]`=1 and `led_in[(i−1) mod 16]`=0. `pos`=i, `code`=k−1.
- Sample register `s` captures `led_in` every cycle. Previous register `p` holds the last accepted sample.
- Step: `s` == {`p`[14:0],`p`[15]} and `s` is legal. Hold: `s` == `p`.
- States:
  - IDLE: `valid`=0. A legal `s` causes load `p`, go to STATIC.
  - STATIC: legal hold stays. A step goes to RUN and pulses `step`. Another legal pattern reloads `p` and stays in STATIC (switch change). Illegal `s` goes to IDLE.
  - RUN: hold stays. A step pulses `step`. Any other change, legal or illegal, goes to FAULT with `err`=1.
  - FAULT: outputs frozen except `err`=1. Only `rst` or `resync` leave it, to IDLE.
- Step counter (4-bit) increments per step. On wrap 15→0, `lap` pulses and `laps` increments mod 256.
- Each step sets `pos` to (`pos`+1) mod 16; `code` is unchanged.
- Interval counter (32-bit, saturating) clears on each step and increments on each RUN hold cycle. `stalled` = counter ≥ 2*countnum. It clears on the next step, `resync`, or `rst`.
- A step detected in the same cycle the interval reaches threshold: step wins and `stalled` stays 0.

## Timing
- Reset or resync values: state IDLE, `p`=0, `valid`=0, `code`=0, `pos`=0, `running`=0, `step`=0, `lap`=0, `laps`=0, `stalled`=0, `err`=0, all counters 0.
- Latency: a change on `led_in` before edge N is captured into `s` at N. Decoded outputs are updated at edge N+1, so outputs reflect input 2 edges later.
- `step` and `lap` are high for exactly one cycle. `lap` coincides with the 16th `step`.
- Back-to-back steps on consecutive cycles are legal; each one pulses `step`.
- `resync` asserted with `rst`: treated as `rst`. `resync` takes effect at the edge it is sampled, and the next cycle resumes from IDLE.

## Test plan
- After `rst`, drive `led_in`=16'h0007 for 3 cycles -> `valid`=1, `code`=2, `pos`=0, `running`=0, `err`=0 at second edge.
- With `countnum`=4, drive 16'h000F then rotate left every 4 cycles 16 times -> 16 `step` pulses, `pos` 0→15→0, `lap` pulse on 16th, `laps`=1, `stalled`=0.
- In RUN at 16'h0030, hold 9 cycles (`countnum`=4) -> `stalled`=1 after the 8th hold cycle; next rotate to 16'h0060 -> `step`=1, `stalled`=0.
- Wrap pattern 16'h8001 -> `pos`=15, `code`=1. Rotate to 16'h0003 -> `step`, `pos`=0.
- In RUN, drive 16'h00FF from 16'h0003 -> FAULT, `err`=1, outputs frozen. Pulse `resync` -> IDLE, `err`=0, `laps`=0.
- In STATIC, drive 16'h0000 -> `valid`=0, IDLE. Drive 16'h1FF0 (9 ones) -> stays IDLE with `valid`=0. Drive 16'h0101 (two runs) -> stays IDLE with `valid`=0.

Source files
------------

// File: rtl/holiday_lights_monitor.sv
// Observer for the 16-bit holiday-light LED bus: decodes the lit run, tracks
// left-rotation steps and laps, and flags stalls and illegal pattern changes.
module holiday_lights_monitor #(
  parameter int unsigned countnum = 100000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] led_in,
  input  logic        resync,
  output logic        valid,
  output logic [2:0]  code,
  output logic [3:0]  pos,
  output logic        running,
  output logic        step,
  output logic        lap,
  output logic [7:0]  laps,
  output logic        stalled,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, STATIC, RUN, FAULT} state_t;

  // Held in 33 bits so the doubled threshold never overflows.
  localparam logic [32:0] stall_thr = 33'(countnum) << 1;

  state_t      state_reg, state_next;
  logic [15:0] s_reg;
  logic [15:0] p_reg, p_next;
  logic        valid_reg, valid_next;
  logic [2:0]  code_reg, code_next;
  logic [3:0]  pos_reg, pos_next;
  logic        step_reg, step_next;
  logic        lap_reg, lap_next;
  logic [7:0]  laps_reg, laps_next;
  logic [3:0]  step_cnt_reg, step_cnt_next;
  logic [31:0] interval_reg, interval_next;
  logic        stalled_reg, stalled_next;
  logic        err_reg, err_next;

  logic [15:0] starts;
  logic [4:0]  ones;
  logic [4:0]  nstarts;
  logic [3:0]  s_pos;
  logic [2:0]  s_code;
  logic        s_legal;
  logic        is_hold;
  logic        is_step;
  logic        take_step;

  // A run starts where a lit bit follows an unlit one, circularly.
  for (genvar gi = 0; gi < 16; gi++) begin : g_start
    assign starts[gi] = s_reg[gi] & ~s_reg[(gi + 15) % 16];
  end

  always_comb begin
    ones    = '0;
    nstarts = '0;
    s_pos   = '0;
    for (int i = 0; i < 16; i++) begin
      ones    = ones + 5'(s_reg[i]);
      nstarts = nstarts + 5'(starts[i]);
      if (starts[i]) begin
        s_pos = 4'(i);
      end
    end
  end

  assign s_code  = 3'(ones - 5'd1);
  assign s_legal = (nstarts == 5'd1) && (ones <= 5'd8);
  assign is_hold = (s_reg == p_reg);
  assign is_step = (s_reg == {p_reg[14:0], p_reg[15]}) && s_legal;

  always_comb begin
    state_next    = state_reg;
    p_next        = p_reg;
    valid_next    = valid_reg;
    code_next     = code_reg;
    pos_next      = pos_reg;
    step_next     = 1'b0;
    lap_next      = 1'b0;
    laps_next     = laps_reg;
    step_cnt_next = step_cnt_reg;
    interval_next = interval_reg;
    stalled_next  = stalled_reg;
    err_next      = err_reg;
    take_step     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (s_legal) begin
          state_next = STATIC;
          p_next     = s_reg;
          valid_next = 1'b1;
          code_next  = s_code;
          pos_next   = s_pos;
        end
      end
      STATIC: begin
        if (!is_hold) begin
          if (is_step) begin
            take_step  = 1'b1;
            state_next = RUN;
          end else if (s_legal) begin
            // Generator switch changed: adopt the new run and keep waiting.
            p_next    = s_reg;
            code_next = s_code;
            pos_next  = s_pos;
          end else begin
            state_next = IDLE;
            p_next     = '0;
            valid_next = 1'b0;
            code_next  = '0;
            pos_next   = '0;
          end
        end
      end
      RUN: begin
        if (is_hold) begin
          if (interval_reg != 32'hFFFF_FFFF) begin
            interval_next = interval_reg + 32'd1;
          end
          stalled_next = ({1'b0, interval_next} >= stall_thr);
        end else if (is_step) begin
          take_step = 1'b1;
        end else begin
          state_next = FAULT;
          err_next   = 1'b1;
        end
      end
      FAULT: begin
      end
    endcase

    // A step always clears the interval, so it beats a same-cycle stall.
    if (take_step) begin
      p_next        = s_reg;
      pos_next      = pos_reg + 4'd1;
      step_next     = 1'b1;
      step_cnt_next = step_cnt_reg + 4'd1;
      interval_next = '0;
      stalled_next  = 1'b0;
      if (step_cnt_reg == 4'd15) begin
        lap_next  = 1'b1;
        laps_next = laps_reg + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_reg <= '0;
    end else begin
      s_reg <= led_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || resync) begin
      state_reg    <= IDLE;
      p_reg        <= '0;
      valid_reg    <= 1'b0;
      code_reg     <= '0;
      pos_reg      <= '0;
      step_reg     <= 1'b0;
      lap_reg      <= 1'b0;
      laps_reg     <= '0;
      step_cnt_reg <= '0;
      interval_reg <= '0;
      stalled_reg  <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      p_reg        <= p_next;
      valid_reg    <= valid_next;
      code_reg     <= code_next;
      pos_reg      <= pos_next;
      step_reg     <= step_next;
      lap_reg      <= lap_next;
      laps_reg     <= laps_next;
      step_cnt_reg <= step_cnt_next;
      interval_reg <= interval_next;
      stalled_reg  <= stalled_next;
      err_reg      <= err_next;
    end
  end

  assign valid   = valid_reg;
  assign code    = code_reg;
  assign pos     = pos_reg;
  assign running = (state_reg == RUN);
  assign step    = step_reg;
  assign lap     = lap_reg;
  assign laps    = laps_reg;
  assign stalled = stalled_reg;
  assign err     = err_reg;

endmodule

// File: tb/tb_holiday_lights_monitor.sv
// Bench for holiday_lights_monitor: directed scenarios followed by random
// LED traffic, checked every cycle against a table-driven reference model.
module tb_holiday_lights_monitor;
  localparam int unsigned CN = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        resync;
  logic [15:0] led;
  logic        valid;
  logic [2:0]  code;
  logic [3:0]  pos;
  logic        running;
  logic        step;
  logic        lap;
  logic [7:0]  laps;
  logic        stalled;
  logic        err;

  always #5 clk = ~clk;

  holiday_lights_monitor #(.countnum(CN)) dut (
    .clk(clk), .rst(rst), .led_in(led), .resync(resync),
    .valid(valid), .code(code), .pos(pos), .running(running),
    .step(step), .lap(lap), .laps(laps), .stalled(stalled), .err(err)
  );

  int compared = 0;
  int mismatched = 0;

  // Every legal pattern, keyed by value, holding code*16 + pos.
  int legal_map [bit [15:0]];

  // Reference model: mode 0 idle, 1 static, 2 run, 3 fault.
  int        m_mode;
  bit [15:0] m_s, m_p;
  int        m_code, m_pos, m_laps, m_steps, m_holds;
  bit        m_valid, m_step, m_lap, m_stalled, m_err;
  int        step_seen, lap_seen;

  function automatic bit [15:0] rotl(bit [15:0] x, int n);
    bit [15:0] r;
    r = x;
    for (int j = 0; j < n; j++) r = {r[14:0], r[15]};
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    compared++;
    assert (obs === exp_v) else begin
      mismatched++;
      $error("FAIL %s at %0t: observed %0h expected %0h", tag, $time, obs, exp_v);
    end
  endtask

  task automatic model_clear();
    m_mode = 0; m_p = '0; m_valid = 0; m_code = 0; m_pos = 0;
    m_laps = 0; m_steps = 0; m_holds = 0;
    m_step = 0; m_lap = 0; m_stalled = 0; m_err = 0;
  endtask

  task automatic model_do_step(input bit [15:0] s);
    m_p = s;
    m_pos = (m_pos + 1) % 16;
    m_step = 1;
    m_steps++;
    if (m_steps % 16 == 0) begin
      m_lap = 1;
      m_laps = (m_laps + 1) % 256;
    end
    m_holds = 0;
    m_stalled = 0;
  endtask

  task automatic model_update(input bit [15:0] s);
    m_step = 0;
    m_lap = 0;
    case (m_mode)
      0: if (legal_map.exists(s)) begin
        m_mode = 1; m_p = s; m_valid = 1;
        m_code = legal_map[s] / 16; m_pos = legal_map[s] % 16;
      end
      1: if (s != m_p) begin
        if (s == rotl(m_p, 1)) begin
          model_do_step(s);
          m_mode = 2;
        end else if (legal_map.exists(s)) begin
          m_p = s; m_code = legal_map[s] / 16; m_pos = legal_map[s] % 16;
        end else begin
          m_mode = 0; m_p = '0; m_valid = 0; m_code = 0; m_pos = 0;
        end
      end
      2: if (s == m_p) begin
        m_holds++;
        m_stalled = (m_holds >= 2 * CN);
      end else if (s == rotl(m_p, 1)) begin
        model_do_step(s);
      end else begin
        m_mode = 3;
        m_err = 1;
      end
      default: ;
    endcase
  endtask

  // One clock: advance the model by the sample captured last edge, then check.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      model_clear();
      m_s = '0;
    end else if (resync) begin
      model_clear();
      m_s = led;
    end else begin
      model_update(m_s);
      m_s = led;
    end
    #1;
    chk("valid",   32'(valid),   32'(m_valid));
    chk("code",    32'(code),    32'(m_code));
    chk("pos",     32'(pos),     32'(m_pos));
    chk("running", 32'(running), 32'(m_mode == 2));
    chk("step",    32'(step),    32'(m_step));
    chk("lap",     32'(lap),     32'(m_lap));
    chk("laps",    32'(laps),    32'(m_laps));
    chk("stalled", 32'(stalled), 32'(m_stalled));
    chk("err",     32'(err),     32'(m_err));
    if (step === 1'b1) step_seen++;
    if (lap === 1'b1) lap_seen++;
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int j = 0; j < n; j++) tick();
  endtask

  initial begin
    bit [15:0] mask;
    int r;
    for (int k = 1; k <= 8; k++) begin
      mask = 16'((1 << k) - 1);
      for (int i = 0; i < 16; i++) legal_map[rotl(mask, i)] = (k - 1) * 16 + i;
    end
    model_clear();
    m_s = '0;

    rst = 1'b1; resync = 1'b0; led = 16'h0000;
    ticks(2);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_laps", 32'(laps), 0);
    $display("reset done: valid=%0d laps=%0d err=%0d", valid, laps, err);
    rst = 1'b0;

    led = 16'h0007;
    ticks(2);
    chk("tp1_valid", 32'(valid), 1);
    chk("tp1_code", 32'(code), 2);
    chk("tp1_pos", 32'(pos), 0);
    chk("tp1_running", 32'(running), 0);
    tick();
    $display("static 0007: valid=%0d code=%0d pos=%0d", valid, code, pos);

    led = 16'h000F;
    ticks(4);
    step_seen = 0; lap_seen = 0;
    for (int i = 0; i < 16; i++) begin
      led = rotl(led, 1);
      ticks(4);
      $display("rotate %0d: led=%04h pos=%0d laps=%0d", i, led, pos, laps);
    end
    chk("lap_steps", 32'(step_seen), 16);
    chk("lap_count", 32'(lap_seen), 1);
    chk("lap_laps", 32'(laps), 1);
    chk("lap_pos", 32'(pos), 0);
    chk("lap_stalled", 32'(stalled), 0);

    led = 16'h0018; resync = 1'b1;
    tick();
    resync = 1'b0;
    ticks(2);
    led = 16'h0030;
    ticks(2);
    chk("stall_step", 32'(step), 1);
    ticks(7);
    chk("stall_h7", 32'(stalled), 0);
    tick();
    chk("stall_h8", 32'(stalled), 1);
    tick();
    led = 16'h0060;
    ticks(2);
    chk("unstall_step", 32'(step), 1);
    chk("unstall_stalled", 32'(stalled), 0);
    $display("stall test: stalled=%0d step=%0d pos=%0d", stalled, step, pos);

    led = 16'h8001; resync = 1'b1;
    tick();
    resync = 1'b0;
    tick();
    chk("wrap_pos", 32'(pos), 15);
    chk("wrap_code", 32'(code), 1);
    led = 16'h0003;
    ticks(2);
    chk("wrap_step", 32'(step), 1);
    chk("wrap_pos0", 32'(pos), 0);
    $display("wrap test: pos=%0d code=%0d", pos, code);

    led = 16'h00FF;
    ticks(2);
    chk("fault_err", 32'(err), 1);
    led = 16'h1234;
    ticks(3);
    chk("fault_pos", 32'(pos), 0);
    chk("fault_code", 32'(code), 1);
    chk("fault_valid", 32'(valid), 1);
    resync = 1'b1;
    tick();
    resync = 1'b0;
    chk("resync_err", 32'(err), 0);
    chk("resync_laps", 32'(laps), 0);
    $display("fault/resync: err=%0d laps=%0d", err, laps);

    led = 16'h0007;
    ticks(3);
    led = 16'h0000;
    ticks(2);
    chk("idle_zero", 32'(valid), 0);
    led = 16'h1FF0;
    ticks(3);
    chk("idle_nine", 32'(valid), 0);
    led = 16'h0101;
    ticks(3);
    chk("idle_two", 32'(valid), 0);
    $display("illegal patterns: valid=%0d running=%0d", valid, running);

    for (int it = 0; it < 600; it++) begin
      r = $urandom_range(0, 99);
      if (it == 300) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end else if (m_mode == 3 && r < 40) begin
        resync = 1'b1;
        tick();
        resync = 1'b0;
      end else if (r < 50) begin
        led = rotl(led, 1);
      end else if (r < 75) begin
        led = led;
      end else if (r < 87) begin
        mask = 16'((1 << $urandom_range(1, 8)) - 1);
        led = rotl(mask, $urandom_range(0, 15));
      end else if (r < 95) begin
        led = 16'($urandom);
      end else begin
        resync = 1'b1;
        tick();
        resync = 1'b0;
      end
      ticks($urandom_range(1, 10));
      $display("rand %0d: led=%04h valid=%0d pos=%0d laps=%0d stalled=%0d err=%0d",
               it, led, valid, pos, laps, stalled, err);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
